// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
//   btn_state_t         : per-channel debounce FSM state
//   DEBOUNCE_CYCLES_DEF : default stable time (1 ms at 50 MHz)
//   HOLD_CYCLES_DEF     : default long-press time (1 s at 50 MHz)
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int HOLD_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchronizer, stable-time debounce FSM,
// and registered single-cycle press / release / long-press pulses.
// Optional feature macro: BUTTON_HOLD_EN (long-press counter and hold pulse).
//   clock_in : system clock
//   reset    : synchronous, active-low
//   btn_n    : raw asynchronous button, 0 = pressed
//   level    : debounced state, 1 = pressed
//   press    : one-cycle pulse on accepted press
//   released : one-cycle pulse on accepted release ("release" is a reserved word)
//   hold     : one-cycle pulse after HOLD_CYCLES continuous PRESSED
//   state    : current FSM state (debug)
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       btn_n,
    output logic       level,
    output logic       press,
    output logic       released,
    output logic       hold,
    output btn_state_t state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("button_channel: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
    end

    logic          s1;
    logic          s2;
    logic          pr;
    logic [CW-1:0] cnt;

    // Synchronized pressed sample (buttons are active-low).
    assign pr = ~s2;

    // Handshake-free block: pulses are asserted for exactly the one cycle
    // following the accepting edge; level follows the debounced state.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            s1       <= btn_n;
            s2       <= s1;
            press    <= 1'b0;
            released <= 1'b0;
            case (state)
                IDLE: begin
                    if (pr) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pr) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pr) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pr) begin
                        // Bounce during release: back to PRESSED, hold keeps counting.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        level    <= 1'b0;
                        released <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_HOLD_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hcnt;
    logic          held;
    logic          to_idle;

    assign held    = (state == PRESSED) || (state == RELEASE_WAIT);
    assign to_idle = (state == RELEASE_WAIT) && !pr && (cnt == CNT_LAST);

    // hcnt saturates at HOLD_CYCLES, so the HOLD_CYCLES-1 -> HOLD_CYCLES step
    // (and hence the pulse) happens at most once per press.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            hcnt <= '0;
            hold <= 1'b0;
        end else begin
            hold <= held && (hcnt == HCNT_LAST);
            if (to_idle) begin
                hcnt <= '0;
            end else if (held && (hcnt != HCNT_MAX)) begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw active-low push-buttons into debounced levels and
// single-cycle press / release / long-press pulses in the clock_in domain.
// Optional feature macro: BUTTON_HOLD_EN (enables the hold outputs; otherwise 0).
//   clock_in : system clock
//   reset    : synchronous, active-low
//   btn_n    : raw asynchronous buttons, 0 = pressed
//   level    : debounced state per button, 1 = pressed
//   press    : one-cycle pulse per accepted press
//   released : one-cycle pulse per accepted release
//   hold     : one-cycle pulse after HOLD_CYCLES continuous pressed
//   state    : per-channel FSM state, channel i at [2*i+1:2*i] (debug)
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     btn_n,
    output logic [N_BTN-1:0]     level,
    output logic [N_BTN-1:0]     press,
    output logic [N_BTN-1:0]     released,
    output logic [N_BTN-1:0]     hold,
    output logic [2*N_BTN-1:0]   state
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_ch (
            .clock_in(clock_in),
            .reset   (reset),
            .btn_n   (btn_n[i]),
            .level   (level[i]),
            .press   (press[i]),
            .released(released[i]),
            .hold    (hold[i]),
            .state   (state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// The reference model treats each channel as a 2-edge delay line feeding a
// run-length rule: the debounced level flips once the synchronized sample has
// disagreed with it on DEBOUNCE_CYCLES+1 consecutive edges; hold fires when the
// number of edges spent with level=1 reaches HOLD_CYCLES.
module tb_button_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int H = 10;
`ifdef BUTTON_HOLD_EN
    localparam logic EXP_HOLD = 1'b1;
`else
    localparam logic EXP_HOLD = 1'b0;
`endif

    logic           clock_in = 1'b0;
    logic           reset    = 1'b0;
    logic [N-1:0]   btn_n    = '1;
    logic [N-1:0]   level;
    logic [N-1:0]   press;
    logic [N-1:0]   released;
    logic [N-1:0]   hold;
    logic [2*N-1:0] state;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clock_in(clock_in),
        .reset   (reset),
        .btn_n   (btn_n),
        .level   (level),
        .press   (press),
        .released(released),
        .hold    (hold),
        .state   (state)
    );

    // ---------------- clock ----------------
    always #5 clock_in = ~clock_in;

    // ---------------- check helpers ----------------
    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_s1 = '1;
    logic [N-1:0] m_s2 = '1;
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel = '0;
    logic [N-1:0] m_hold = '0;
    int           m_run [N];
    int           m_hc [N];
    bit           model_valid = 1'b0;

    always @(posedge clock_in) begin
        logic pr;
        logic was;
        if (!reset) begin
            m_s1 = '1;
            m_s2 = '1;
            m_level = '0;
            m_press = '0;
            m_rel = '0;
            m_hold = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_hc[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                pr = ~m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_n[i];
                was = m_level[i];
                m_press[i] = 1'b0;
                m_rel[i] = 1'b0;
                m_hold[i] = 1'b0;
                if (pr != was) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == D + 1) begin
                    m_level[i] = pr;
                    m_press[i] = pr;
                    m_rel[i] = ~pr;
                    m_run[i] = 0;
                end
`ifdef BUTTON_HOLD_EN
                if (was) begin
                    if (m_hc[i] == H - 1) m_hold[i] = 1'b1;
                    if (m_hc[i] < H) m_hc[i]++;
                end
`endif
                if (was && !m_level[i]) m_hc[i] = 0;
            end
        end
        model_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock_in) begin
        if (model_valid) begin
            check_vec("model_level", level, m_level);
            check_vec("model_press", press, m_press);
            check_vec("model_release", released, m_rel);
            check_vec("model_hold", hold, m_hold);
        end
    end

    // ---------------- driver ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    int hold_left [N];
    int pulses;
    int pulse_idx;
    logic seen;

    initial begin
        // Reset state
        wait_cycles(3);
        check_vec("reset_level", level, 2'b00);
        check_vec("reset_press", press, 2'b00);
        check_vec("reset_release", released, 2'b00);
        check_vec("reset_hold", hold, 2'b00);
        reset = 1'b1;
        wait_cycles(5);

        // Clean press on ch0: press after edge k+6, hold 10 edges later
        btn_n[0] = 1'b0;
        wait_cycles(6);
        check_vec("press_not_early", press, 2'b00);
        check_vec("level_not_early", level, 2'b00);
        wait_cycles(1);
        check_vec("press_latency", press, 2'b01);
        check_vec("level_latency", level, 2'b01);
        wait_cycles(9);
        check_vec("hold_not_early", hold, 2'b00);
        wait_cycles(1);
        check_vec("hold_latency", hold, {1'b0, EXP_HOLD});
        btn_n[0] = 1'b1;
        wait_cycles(7);
        check_vec("release_latency", released, 2'b01);
        check_vec("level_after_release", level, 2'b00);
        wait_cycles(5);

        // Reset while ch0 is PRESSED, then release reset with button still down
        btn_n[0] = 1'b0;
        wait_cycles(12);
        reset = 1'b0;
        wait_cycles(1);
        check_vec("midreset_level", level, 2'b00);
        check_vec("midreset_press", press, 2'b00);
        check_vec("midreset_release", released, 2'b00);
        check_vec("midreset_hold", hold, 2'b00);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(6);
        check_vec("repress_not_early", press, 2'b00);
        wait_cycles(1);
        check_vec("repress_after_reset", press, 2'b01);
        btn_n = 2'b11;
        wait_cycles(15);

        // Glitch rejection on ch1
        btn_n[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) btn_n[1] = 1'b1;
            wait_cycles(1);
            seen = seen | level[1] | press[1] | released[1];
        end
        check_vec("glitch_rejected", {1'b0, seen}, 2'b00);

        // Simultaneous press and release on both channels
        btn_n = 2'b00;
        wait_cycles(7);
        check_vec("simul_press", press, 2'b11);
        btn_n = 2'b11;
        wait_cycles(7);
        check_vec("simul_release", released, 2'b11);
        wait_cycles(5);

        // Bounce on ch0: low 3, high 1, low 10
        pulses = 0;
        pulse_idx = -1;
        for (int i = 0; i < 24; i++) begin
            btn_n[0] = (i == 3 || i >= 14) ? 1'b1 : 1'b0;
            wait_cycles(1);
            if (press[0]) begin
                pulses++;
                pulse_idx = i;
            end
        end
        check_int("bounce_press_count", pulses, 1);
        check_int("bounce_press_edge", pulse_idx, 10);
        wait_cycles(10);

        // Randomized stimulus against the model
        for (int i = 0; i < N; i++) hold_left[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (hold_left[i] == 0) begin
                    btn_n[i] = 1'($urandom_range(0, 1));
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25))
                                                               : int'($urandom_range(1, 4));
                end
                hold_left[i]--;
            end
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            wait_cycles(1);
        end
        reset = 1'b1;
        btn_n = 2'b11;
        wait_cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
